axilite_uart_responder: RTL



---
 rtl/axilite_uart_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axilite_uart_responder.sv
// AXI4-Lite console responder with a UART-Lite register map (RX, TX, STAT, CTRL) and TX/RX byte FIFOs.
// Build with UARTLITE_IRQ_EN defined to add the irq output.
module axilite_uart_responder #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  uncoreclk,
    input  logic                  uncore_rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [1:0]            dbg_state
`ifdef UARTLITE_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WRESP = 2'd1, RRESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            token_wr_q, token_wr_d;
    logic            wr_elig, rd_elig, grant_wr, grant_rd;
    logic [1:0]      wr_sel, rd_sel;
    logic [31:0]     rd_mux;
    logic            overrun_q, intr_en_q;

    logic [7:0]      tx_mem [FIFO_DEPTH];
    logic [7:0]      rx_mem [FIFO_DEPTH];
    logic [PW-1:0]   tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic            tx_full, tx_empty, rx_full, rx_nempty;
    logic            tx_push, tx_pop, rx_push, rx_pop, rx_ovf;
    logic            ctrl_wr, flush_tx, flush_rx, stat_rd;
    logic            unused_bits;

    // Every channel is valid/ready: a beat moves on a rising edge where both are high.
    // awready/wready/arready are raised only in the single grant cycle; bvalid/rvalid
    // are held from the cycle after the grant until the master's bready/rready.
    assign wr_elig = s_axi_awvalid && s_axi_wvalid;
    assign rd_elig = s_axi_arvalid;
    assign wr_sel  = s_axi_awaddr[3:2];
    assign rd_sel  = s_axi_araddr[3:2];

    always_comb begin
        state_d    = state_q;
        token_wr_d = token_wr_q;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!uncore_rst) begin
                    if (wr_elig && (!rd_elig || token_wr_q)) grant_wr = 1'b1;
                    else if (rd_elig)                         grant_rd = 1'b1;
                    // The token only moves when it actually arbitrated a contention.
                    if (wr_elig && rd_elig) token_wr_d = !grant_wr;
                    if (grant_wr)      state_d = WRESP;
                    else if (grant_rd) state_d = RRESP;
                end
            end
            WRESP:   if (s_axi_bready) state_d = IDLE;
            RRESP:   if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;
    assign s_axi_arready = grant_rd;
    assign s_axi_bvalid  = (state_q == WRESP);
    assign s_axi_rvalid  = (state_q == RRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign dbg_state     = state_q;

    assign tx_full   = (tx_cnt_q == DEPTH_C);
    assign tx_empty  = (tx_cnt_q == '0);
    assign rx_full   = (rx_cnt_q == DEPTH_C);
    assign rx_nempty = (rx_cnt_q != '0);
    assign tx_valid  = !tx_empty;
    assign tx_data   = tx_mem[tx_rd_ptr];

    assign ctrl_wr  = grant_wr && (wr_sel == 2'd3);
    assign flush_tx = ctrl_wr && s_axi_wdata[0];
    assign flush_rx = ctrl_wr && s_axi_wdata[1];
    assign stat_rd  = grant_rd && (rd_sel == 2'd2);
    assign rx_pop   = grant_rd && (rd_sel == 2'd0) && rx_nempty;
    assign tx_pop   = tx_valid && tx_ready && !flush_tx;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign tx_push  = grant_wr && (wr_sel == 2'd1) && s_axi_wstrb[0] && (!tx_full || tx_pop);
    assign rx_push  = rx_valid && (!rx_full || rx_pop) && !flush_rx;
    assign rx_ovf   = rx_valid && rx_full && !rx_pop && !flush_rx;

    always_comb begin
        rd_mux = 32'h0;
        case (rd_sel)
            2'd0:    if (rx_nempty) rd_mux = {24'h0, rx_mem[rx_rd_ptr]};
            2'd2:    rd_mux = {26'h0, overrun_q, intr_en_q, tx_full, tx_empty, rx_full, rx_nempty};
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        tx_cnt_d = flush_tx ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = flush_rx ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_ff @(posedge uncoreclk) begin
        if (uncore_rst) begin
            state_q     <= IDLE;
            token_wr_q  <= 1'b0;
            s_axi_rdata <= 32'h0;
            overrun_q   <= 1'b0;
            intr_en_q   <= 1'b0;
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            token_wr_q <= token_wr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            if (grant_rd) s_axi_rdata <= rd_mux;
            if (ctrl_wr)  intr_en_q <= s_axi_wdata[4];
            // A fresh overrun in the same cycle as a STAT read stays visible.
            if (rx_ovf)       overrun_q <= 1'b1;
            else if (stat_rd) overrun_q <= 1'b0;
            if (flush_tx) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            if (flush_rx) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge uncoreclk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= s_axi_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

`ifdef UARTLITE_IRQ_EN
    always_ff @(posedge uncoreclk) begin
        if (uncore_rst) irq <= 1'b0;
        else irq <= intr_en_q && ((rx_cnt_q == '0 && rx_cnt_d != '0) ||
                                  (tx_cnt_q != '0 && tx_cnt_d == '0));
    end
`endif

    assign unused_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                           s_axi_araddr[ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                           s_axi_wdata[31:8], s_axi_wstrb[3:1]};

endmodule
